// File: rtl/can_crc_pkg.sv
// Shared CAN CRC-15 constants, checker state encoding and the single-bit LFSR step
// used by both the transmit and receive CRC logic.
package can_crc_pkg;

    localparam int                CRC_W    = 15;
    localparam logic [CRC_W-1:0]  POLY     = 15'h4599;
    localparam logic [CRC_W-1:0]  INIT     = 15'h0000;
    localparam int                CRC_BITS = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRCF = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [CRC_W-1:0] crc15_step(input logic [CRC_W-1:0] crc, input logic din);
        logic nxt;
        nxt = din ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (nxt ? POLY : '0);
    endfunction

endpackage

// File: rtl/rcrc_lfsr.sv
// CRC-15 shift register for the receive checker; clear wins over enable.
module rcrc_lfsr
    import can_crc_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clock) begin
        if (!reset)
            crc <= INIT;
        else if (clear)
            crc <= INIT;
        else if (enable)
            crc <= crc15_step(crc, bit_in);
    end

endmodule

// File: rtl/rcrc_check.sv
// Receive-side CAN CRC-15 checker: steps the LFSR over data and CRC field bits and
// flags ok/err once all 15 CRC bits have arrived (or the field ends early).
module rcrc_check
    import can_crc_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             crc_phase,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [CRC_W-1:0] crc_reg
);

    state_t           state;
    logic [3:0]       cnt;
    logic             lfsr_en;
    logic [CRC_W-1:0] crc_next;

    // A strobe coinciding with start is dropped; a data-phase bit inside CRCF is never stepped.
    always_comb begin
        lfsr_en  = bit_valid && !start &&
                   (state == DATA || (state == CRCF && crc_phase));
        crc_next = crc15_step(crc_reg, bit_in);
    end

    rcrc_lfsr u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .clear  (start),
        .enable (lfsr_en),
        .bit_in (bit_in),
        .crc    (crc_reg)
    );

    assign busy = (state == DATA) || (state == CRCF);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            done    <= 1'b0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state   <= DATA;
                cnt     <= 4'd0;
                crc_ok  <= 1'b0;
                crc_err <= 1'b0;
            end else begin
                case (state)
                    DATA: begin
                        if (bit_valid && crc_phase) begin
                            cnt   <= 4'd1;
                            state <= CRCF;
                        end
                    end
                    CRCF: begin
                        if (bit_valid) begin
                            if (crc_phase) begin
                                cnt <= cnt + 4'd1;
                                // Judge the post-step value so flags line up with the done pulse.
                                if (cnt == 4'(CRC_BITS - 1)) begin
                                    state   <= DONE;
                                    done    <= 1'b1;
                                    crc_ok  <= (crc_next == '0);
                                    crc_err <= (crc_next != '0);
                                end
                            end else begin
                                state   <= DONE;
                                done    <= 1'b1;
                                crc_ok  <= 1'b0;
                                crc_err <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/rcrc_check.md
Name: rcrc_check

Overview:
- Receive-side CAN CRC-15 checker. It is the counterpart of the transmit CRC cell chain.
- Consumes destuffed receive bits from the bit-timing/receive FSM one strobe at a time.
- Runs the same CRC-15 LFSR over the data bits and then over the 15 received CRC bits.
- Reports crc_ok/crc_err once the CRC field is complete, for use by the ACK/error logic.

Parameters:
- CRC_W, 15, LFSR width.
- POLY, 15'h4599, generator polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 without the x^15 term.
- INIT, 15'h0000, LFSR value loaded on start.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse at SOF: clears the LFSR and arms the checker.
- bit_valid  in  1  strobe; bit_in is consumed only in cycles where this is 1.
- bit_in  in  1  destuffed receive bit, MSB-first frame order.
- crc_phase  in  1  high while the strobed bits belong to the 15-bit CRC field.
- busy  out  1  high in DATA or CRCF.
- done  out  1  one-cycle pulse when the check result becomes valid.
- crc_ok  out  1  result flag, held until the next start or reset.
- crc_err  out  1  result flag, held until the next start or reset.
- crc_reg  out  CRC_W  current LFSR contents, for debug and error capture.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, crc_reg=INIT, bit counter=0.
  - busy=0, done=0, crc_ok=0, crc_err=0.
  - Reset has priority over all inputs, including mid-frame; the next start is needed to re-arm.
- LFSR step, on every accepted bit in DATA or CRCF:
  - nxt = bit_in ^ crc_reg[CRC_W-1].
  - crc_reg <= {crc_reg[CRC_W-2:0],1'b0} ^ (nxt ? POLY : 0).
  - Latency is one clock from the strobe to the updated crc_reg.
- States: IDLE, DATA, CRCF, DONE.
  - IDLE: ignore bit_valid. start -> DATA, crc_reg<=INIT, flags cleared.
  - DATA: on bit_valid & !crc_phase, step the LFSR and stay. On bit_valid & crc_phase, step the LFSR, set cnt<=1 and go to CRCF. That bit is the first CRC bit.
  - CRCF: on bit_valid & crc_phase, step the LFSR and increment cnt (4-bit). When the accepted bit is the 15th (cnt==14 before the increment), go to DONE next cycle.
  - CRCF early exit: if bit_valid & !crc_phase arrives with fewer than 15 CRC bits, the bit is not stepped. Go to DONE with a forced error: crc_err=1, crc_ok=0.
  - DONE entry cycle: done=1 for exactly one cycle. crc_ok=(crc_reg==0), crc_err=(crc_reg!=0), unless the error was forced. Then stay in DONE with flags held and busy=0 until start.
- start in any state (DATA, CRCF, DONE included): restart. crc_reg<=INIT, cnt<=0, flags<=0, state<=DATA.
- bit_valid in the same cycle as start is ignored; the first data bit must come in a later cycle.
- crc_ok and crc_err are never 1 simultaneously. Both are 0 while busy.
- An empty data field (first strobed bit already has crc_phase=1) is legal; the LFSR starts from INIT.
- bit_valid=0 cycles never change state, LFSR or counter.

Decomposition:
- Package can_crc_pkg:
  - CRC_W, POLY and INIT constants.
  - State enum: IDLE, DATA, CRCF, DONE.
  - CRC bit-count constant 15.
  - Function crc15_step(crc, bit), shared with the transmit side and the bench model.
- Sub-module rcrc_lfsr:
  - Ports: clock, reset, clear, enable, bit_in, crc.
  - The 15-bit register with clear priority over enable.
- The FSM, counter and result flags live in rcrc_check.

Test Plan:
- Reset sequence, then start; data bit 1; CRC bits 100010110011001 (15'h4599) with crc_phase=1. Required: crc_reg=15'h4599 after the data bit, done pulse, crc_ok=1, crc_err=0, crc_reg=0.
- Same frame with the 8th CRC bit inverted. Required: done pulse, crc_err=1, crc_ok=0, crc_reg!=0.
- start, 8 data bits 0x00, 15 CRC bits 0. Required: crc_ok=1. Then apply start. Required: flags clear and busy=1 on the next cycle.
- start, data bit 1, only 10 CRC bits, then bit_valid with crc_phase=0. Required: forced crc_err=1, done pulse, crc_reg unchanged by the last bit.
- Gaps of 0-3 idle cycles between bit_valid strobes, plus a start coinciding with bit_valid. Required: results identical to the back-to-back case and the coincident bit ignored.
- reset asserted mid-CRCF. Required: all outputs 0 next cycle, state IDLE, and strobes ignored until start.
